// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, requests words from the
// instruction cache and presents them to the IF/ID pipeline register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        CCLK,
    input  logic        RESET,
    input  logic        PCWrite,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    output logic        IC_REQ,
    output logic [31:0] IC_ADDR,
    input  logic        IC_READY,
    input  logic [31:0] IC_RDATA,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PC_4,
    output logic        IF_Valid,
    output logic        IFIDWrite,
    output logic        IF_Flush,
    output logic        MISS_STALL,
    output logic        FETCH_ERR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr_buf;
    logic [31:0] pc4_buf;
    logic [31:0] redir_pc;
    logic        redir_pend;
    logic [7:0]  wait_cnt;
    logic        flush_q;
    logic        err_q;

    logic [31:0] br_tgt;
    logic [31:0] pc_plus4;
    logic        in_hold;

    assign br_tgt   = {BR_TARGET[31:2], 2'b00};
    assign pc_plus4 = pc + 32'd4;
    assign in_hold  = (state == HOLD);

    // Fetch FSM with PC, instruction buffer, pending redirect and wait timer
    always_ff @(posedge CCLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr_buf  <= 32'd0;
            pc4_buf    <= 32'd0;
            redir_pc   <= 32'd0;
            redir_pend <= 1'b0;
            wait_cnt   <= 8'd0;
            flush_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            flush_q <= BR_TAKEN;
            unique case (state)
                IDLE: begin
                    if (BR_TAKEN) begin
                        pc <= br_tgt;
                    end
                    wait_cnt <= 8'd0;
                    state    <= REQ;
                end
                REQ: begin
                    if (IC_READY) begin
                        wait_cnt <= 8'd0;
                        if (redir_pend || BR_TAKEN) begin
                            // Response belongs to a squashed path; retry at target
                            pc         <= BR_TAKEN ? br_tgt : redir_pc;
                            redir_pend <= 1'b0;
                        end else begin
                            instr_buf <= IC_RDATA;
                            pc4_buf   <= pc_plus4;
                            state     <= HOLD;
                        end
                    end else begin
                        if (BR_TAKEN) begin
                            redir_pend <= 1'b1;
                            redir_pc   <= br_tgt;
                        end
                        if (wait_cnt != WAIT_LIMIT) begin
                            wait_cnt <= wait_cnt + 8'd1;
                            if ((wait_cnt + 8'd1) == WAIT_LIMIT) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (BR_TAKEN) begin
                        pc       <= br_tgt;
                        wait_cnt <= 8'd0;
                        state    <= REQ;
                    end else if (PCWrite) begin
                        pc       <= pc_plus4;
                        wait_cnt <= 8'd0;
                        state    <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Cache request and IF-stage outputs decoded from the current state
    always_comb begin
        IC_REQ         = (state == REQ);
        IC_ADDR        = pc;
        MISS_STALL     = (state == REQ);
        IF_Valid       = in_hold;
        IF_Instruction = in_hold ? instr_buf : 32'd0;
        IF_PC_4        = in_hold ? pc4_buf : 32'd0;
        IFIDWrite      = in_hold & PCWrite & ~BR_TAKEN;
        IF_Flush       = flush_q;
        FETCH_ERR      = err_q;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: cycle vector table fed through
// an expected-value queue, plus hand sequences for reset corners.
module tb_if_fetch_unit;

    logic        CCLK;
    logic        RESET;
    logic        PCWrite;
    logic        BR_TAKEN;
    logic [31:0] BR_TARGET;
    logic        IC_REQ;
    logic [31:0] IC_ADDR;
    logic        IC_READY;
    logic [31:0] IC_RDATA;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC_4;
    logic        IF_Valid;
    logic        IFIDWrite;
    logic        IF_Flush;
    logic        MISS_STALL;
    logic        FETCH_ERR;

    int n_checks;
    int n_fail;

    if_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .MAX_WAIT(4)
    ) dut (
        .CCLK          (CCLK),
        .RESET         (RESET),
        .PCWrite       (PCWrite),
        .BR_TAKEN      (BR_TAKEN),
        .BR_TARGET     (BR_TARGET),
        .IC_REQ        (IC_REQ),
        .IC_ADDR       (IC_ADDR),
        .IC_READY      (IC_READY),
        .IC_RDATA      (IC_RDATA),
        .IF_Instruction(IF_Instruction),
        .IF_PC_4       (IF_PC_4),
        .IF_Valid      (IF_Valid),
        .IFIDWrite     (IFIDWrite),
        .IF_Flush      (IF_Flush),
        .MISS_STALL    (MISS_STALL),
        .FETCH_ERR     (FETCH_ERR)
    );

    initial CCLK = 1'b0;
    always #5 CCLK = ~CCLK;

    typedef struct {
        logic        pcw;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        ifidw;
        logic        flush;
        logic        stall;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic v(
        input logic pcw, input logic br, input logic [31:0] tgt,
        input logic rdy, input logic [31:0] rdata,
        input logic req, input logic [31:0] addr, input logic valid,
        input logic [31:0] instr, input logic [31:0] pc4,
        input logic ifidw, input logic flush, input logic stall,
        input logic err
    );
        vec_t t;
        t.pcw = pcw; t.br = br; t.tgt = tgt; t.rdy = rdy; t.rdata = rdata;
        t.req = req; t.addr = addr; t.valid = valid; t.instr = instr;
        t.pc4 = pc4; t.ifidw = ifidw; t.flush = flush; t.stall = stall;
        t.err = err;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input vec_t e);
        chk("IC_REQ", idx, 32'(IC_REQ), 32'(e.req));
        chk("IC_ADDR", idx, IC_ADDR, e.addr);
        chk("IF_Valid", idx, 32'(IF_Valid), 32'(e.valid));
        chk("IF_Instruction", idx, IF_Instruction, e.instr);
        chk("IF_PC_4", idx, IF_PC_4, e.pc4);
        chk("IFIDWrite", idx, 32'(IFIDWrite), 32'(e.ifidw));
        chk("IF_Flush", idx, 32'(IF_Flush), 32'(e.flush));
        chk("MISS_STALL", idx, 32'(MISS_STALL), 32'(e.stall));
        chk("FETCH_ERR", idx, 32'(FETCH_ERR), 32'(e.err));
    endtask

    localparam logic [31:0] A0 = 32'hA000_0000;
    localparam logic [31:0] A1 = 32'hA111_1111;
    localparam logic [31:0] A2 = 32'hA222_2222;
    localparam logic [31:0] A3 = 32'hA333_3333;
    localparam logic [31:0] M  = 32'h8C01_0004;
    localparam logic [31:0] B0 = 32'hB000_00B0;
    localparam logic [31:0] B1 = 32'hB111_00B1;
    localparam logic [31:0] B2 = 32'hB222_00B2;
    localparam logic [31:0] C0 = 32'hC000_00C0;
    localparam logic [31:0] C1 = 32'hC111_00C1;
    localparam logic [31:0] DD = 32'hDEAD_BEEF;

    initial begin
        vec_t e;
        n_checks  = 0;
        n_fail    = 0;
        RESET     = 1'b1;
        PCWrite   = 1'b0;
        BR_TAKEN  = 1'b0;
        BR_TARGET = 32'd0;
        IC_READY  = 1'b0;
        IC_RDATA  = 32'd0;

        // zero-wait hits
        v(1,0,0,1,A0, 0,32'h0,0,0,0,0,0,0,0);
        v(1,0,0,1,A0, 1,32'h0,0,0,0,0,0,1,0);
        v(1,0,0,1,A0, 0,32'h0,1,A0,32'h4,1,0,0,0);
        v(1,0,0,1,A1, 1,32'h4,0,0,0,0,0,1,0);
        v(1,0,0,1,A1, 0,32'h4,1,A1,32'h8,1,0,0,0);
        v(1,0,0,1,A2, 1,32'h8,0,0,0,0,0,1,0);
        v(1,0,0,1,A2, 0,32'h8,1,A2,32'hC,1,0,0,0);
        v(1,0,0,1,A3, 1,32'hC,0,0,0,0,0,1,0);
        v(1,0,0,1,A3, 0,32'hC,1,A3,32'h10,1,0,0,0);
        // miss with three wait cycles at 0x10
        for (int i = 0; i < 3; i++)
            v(1,0,0,0,0, 1,32'h10,0,0,0,0,0,1,0);
        v(1,0,0,1,M, 1,32'h10,0,0,0,0,0,1,0);
        // stall five cycles in HOLD
        for (int i = 0; i < 5; i++)
            v(0,0,0,0,0, 0,32'h10,1,M,32'h14,0,0,0,0);
        v(1,0,0,0,0, 0,32'h10,1,M,32'h14,1,0,0,0);
        // branch from HOLD, low target bits dropped
        v(1,0,0,1,B0, 1,32'h14,0,0,0,0,0,1,0);
        v(1,1,32'h103,1,B0, 0,32'h14,1,B0,32'h18,0,0,0,0);
        v(1,0,0,1,B1, 1,32'h100,0,0,0,0,1,1,0);
        v(1,1,32'h3C,1,B1, 0,32'h100,1,B1,32'h104,0,0,0,0);
        v(1,0,0,1,B2, 1,32'h3C,0,0,0,0,1,1,0);
        v(1,0,0,1,B2, 0,32'h3C,1,B2,32'h40,1,0,0,0);
        // branch during miss at 0x40: address held, data discarded
        v(1,0,0,0,0, 1,32'h40,0,0,0,0,0,1,0);
        v(1,1,32'h200,0,0, 1,32'h40,0,0,0,0,0,1,0);
        v(1,0,0,0,0, 1,32'h40,0,0,0,0,1,1,0);
        v(1,0,0,1,DD, 1,32'h40,0,0,0,0,0,1,0);
        v(1,0,0,1,C0, 1,32'h200,0,0,0,0,0,1,0);
        // wrap of PC+4 at the top of the address space
        v(1,1,32'hFFFF_FFFF,1,C0, 0,32'h200,1,C0,32'h204,0,0,0,0);
        v(1,0,0,1,C1, 1,32'hFFFF_FFFC,0,0,0,0,1,1,0);
        v(1,0,0,1,C1, 0,32'hFFFF_FFFC,1,C1,32'h0,1,0,0,0);
        // timeout: error after four wait cycles, sticky, request held
        for (int i = 0; i < 4; i++)
            v(1,0,0,0,0, 1,32'h0,0,0,0,0,0,1,0);
        for (int i = 0; i < 2; i++)
            v(1,0,0,0,0, 1,32'h0,0,0,0,0,0,1,1);

        // reset state while RESET is held
        repeat (2) @(posedge CCLK);
        #1;
        PCWrite  = 1'b1;
        IC_READY = 1'b1;
        @(negedge CCLK);
        e = '{1'b1,1'b0,32'd0,1'b1,32'd0,1'b0,32'd0,1'b0,32'd0,32'd0,
              1'b0,1'b0,1'b0,1'b0};
        chk_all(-1, e);
        @(posedge CCLK);
        #1;
        RESET = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            PCWrite   = vecs[i].pcw;
            BR_TAKEN  = vecs[i].br;
            BR_TARGET = vecs[i].tgt;
            IC_READY  = vecs[i].rdy;
            IC_RDATA  = vecs[i].rdata;
            sb.push_back(vecs[i]);
            @(negedge CCLK);
            e = sb.pop_front();
            chk_all(i, e);
            @(posedge CCLK);
            #1;
        end

        // asynchronous reset mid-request with a response on the bus
        PCWrite  = 1'b1;
        BR_TAKEN = 1'b0;
        IC_READY = 1'b1;
        IC_RDATA = 32'hEEEE_EEEE;
        #1;
        RESET = 1'b1;
        #1;
        e = '{1'b1,1'b0,32'd0,1'b1,32'd0,1'b0,32'd0,1'b0,32'd0,32'd0,
              1'b0,1'b0,1'b0,1'b0};
        chk_all(100, e);
        @(posedge CCLK);
        #1;
        RESET = 1'b0;
        // redirect taken while in IDLE
        BR_TAKEN  = 1'b1;
        BR_TARGET = 32'h0000_0301;
        @(negedge CCLK);
        chk_all(101, e);
        @(posedge CCLK);
        #1;
        BR_TAKEN = 1'b0;
        @(negedge CCLK);
        e = '{1'b1,1'b0,32'd0,1'b1,32'd0,1'b1,32'h300,1'b0,32'd0,32'd0,
              1'b0,1'b1,1'b1,1'b0};
        chk_all(102, e);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
